// File: rtl/sync_arb_pkg.sv
// Shared types and constants for the sync-channel source arbiter.
// Holds the FSM encoding, counter widths and the elaboration-time width helper.
package sync_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int CNT_W = 16;
  localparam int GAP_W = 4;

  // Smallest r with 2**r >= value; used to validate the ID width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: round-robin after ptr, or lowest index first.
// Purely combinational; the caller registers the result.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            mode,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    gnt_id = '0;
    idx    = '0;
    if (mode) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) gnt_id = IDW'(i);
      end
    end else begin
      // Walk offsets downwards so the requester nearest after ptr is assigned last.
      for (int i = NREQ; i >= 1; i--) begin
        idx = IDW'((int'(ptr) + i) % NREQ);
        if (req[idx]) gnt_id = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sync_chan_arb.sv
// Shares one vld/ack CDC sync channel between NREQ requesters in the source domain.
// Captures the winner's payload tagged with its ID, waits for the channel ack, then acks the winner.
module sync_chan_arb
  import sync_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int IDW     = 2,
  parameter int MIN_GAP = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*DWIDTH-1:0]  req_data,
  output logic [NREQ-1:0]         req_ack,
  input  logic                    prio_mode,
  output logic                    ch_vld,
  output logic [IDW+DWIDTH-1:0]   ch_din,
  input  logic                    ch_ack,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_cnt,
  output logic                    err,
  input  logic                    err_clr
);

  if (clog2(NREQ) > IDW || NREQ < 2 || NREQ > 16 || MIN_GAP < 0 || MIN_GAP > 15) begin : g_bad_param
    $error("sync_chan_arb: illegal NREQ/IDW/MIN_GAP combination");
  end

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP > 0 ? MIN_GAP - 1 : 0);

  state_t                  state, state_d;
  logic [IDW-1:0]          ptr, ptr_d;
  logic [IDW-1:0]          grant_id, grant_d;
  logic [GAP_W-1:0]        gap_cnt, gap_d;
  logic                    vld_d, busy_d, err_d;
  logic [IDW+DWIDTH-1:0]   din_d;
  logic [NREQ-1:0]         ack_d;
  logic [CNT_W-1:0]        cnt_d;
  logic [IDW-1:0]          pick_id;
  logic                    pick_any;
  logic [DWIDTH-1:0]       payload [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign payload[g] = req_data[g*DWIDTH +: DWIDTH];
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req_vld),
    .ptr    (ptr),
    .mode   (prio_mode),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    grant_d = grant_id;
    gap_d   = gap_cnt;
    vld_d   = ch_vld;
    din_d   = ch_din;
    ack_d   = '0;
    cnt_d   = xfer_cnt;
    case (state)
      IDLE: if (pick_any) begin
        grant_d = pick_id;
        din_d   = {pick_id, payload[pick_id]};
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: if (ch_ack) begin
        vld_d           = 1'b0;
        ack_d[grant_id] = 1'b1;
        ptr_d           = grant_id;
        cnt_d           = xfer_cnt + 1'b1;
        state_d         = DONE;
      end
      // req_vld is ignored here so the winner has one edge to withdraw.
      DONE: begin
        gap_d   = '0;
        state_d = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
        else                     gap_d   = gap_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A new spurious ack outranks a simultaneous clear.
    err_d = err;
    if (err_clr)                 err_d = 1'b0;
    if (ch_ack && state != SEND) err_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr      <= IDW'(NREQ - 1);
      grant_id <= '0;
      gap_cnt  <= '0;
      ch_vld   <= 1'b0;
      ch_din   <= '0;
      req_ack  <= '0;
      busy     <= 1'b0;
      xfer_cnt <= '0;
      err      <= 1'b0;
    end else begin
      ptr      <= ptr_d;
      grant_id <= grant_d;
      gap_cnt  <= gap_d;
      ch_vld   <= vld_d;
      ch_din   <= din_d;
      req_ack  <= ack_d;
      busy     <= busy_d;
      xfer_cnt <= cnt_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_sync_chan_arb.sv
// Self-checking bench for sync_chan_arb: vector table, fairness/priority runs,
// randomized traffic against an arithmetic arbitration model, error, reset, wrap and gap sequences.
module tb_sync_chan_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic [NREQ-1:0]      req_vld = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ack;
  logic                 prio_mode = 1'b0;
  logic                 ch_vld;
  logic [IDW+DW-1:0]    ch_din;
  logic                 ch_ack = 1'b0;
  logic                 busy;
  logic [15:0]          xfer_cnt;
  logic                 err;
  logic                 err_clr = 1'b0;

  // Second instance with an inter-transfer gap.
  logic [NREQ-1:0]      g_req_vld = '0;
  logic [NREQ*DW-1:0]   g_req_data = 32'h44332211;
  logic [NREQ-1:0]      g_req_ack;
  logic                 g_ch_vld;
  logic [IDW+DW-1:0]    g_ch_din;
  logic                 g_ch_ack = 1'b0;
  logic                 g_busy;
  logic [15:0]          g_xfer_cnt;
  logic                 g_err;

  sync_chan_arb #(.NREQ(NREQ), .DWIDTH(DW), .IDW(IDW), .MIN_GAP(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_vld(req_vld), .req_data(req_data),
    .req_ack(req_ack), .prio_mode(prio_mode), .ch_vld(ch_vld), .ch_din(ch_din),
    .ch_ack(ch_ack), .busy(busy), .xfer_cnt(xfer_cnt), .err(err), .err_clr(err_clr)
  );

  sync_chan_arb #(.NREQ(NREQ), .DWIDTH(DW), .IDW(IDW), .MIN_GAP(3)) dut_gap (
    .clk_i(clk_i), .rst_i(rst_i), .req_vld(g_req_vld), .req_data(g_req_data),
    .req_ack(g_req_ack), .prio_mode(1'b0), .ch_vld(g_ch_vld), .ch_din(g_ch_din),
    .ch_ack(g_ch_ack), .busy(g_busy), .xfer_cnt(g_xfer_cnt), .err(g_err), .err_clr(1'b0)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr = NREQ - 1;
  logic [15:0] m_cnt = '0;
  int          acks [NREQ];

  typedef struct {
    logic [NREQ-1:0] req;
    bit              mode;
    int              delay;
    logic [IDW-1:0]  exp_id;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = set requester at the smallest distance from the start point (ptr+1, or 0 in priority mode).
  function automatic logic [IDW-1:0] model_pick(input logic [NREQ-1:0] m, input bit mode, input int p);
    int best, bd, d;
    best = 0;
    bd   = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (m[i]) begin
        d = mode ? i : (i - p - 1 + 2 * NREQ) % NREQ;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return IDW'(best);
  endfunction

  // One complete transfer starting at a negedge in IDLE; returns at the next IDLE negedge.
  task automatic xfer(input logic [NREQ-1:0] mask, input bit mode, input logic [NREQ*DW-1:0] data,
                      input int delay, input logic [IDW-1:0] exp_id, input bit drop);
    logic [IDW+DW-1:0] exp_din;
    logic [NREQ-1:0]   oh;
    exp_din    = {exp_id, data[exp_id*DW +: DW]};
    oh         = '0;
    oh[exp_id] = 1'b1;
    req_vld    = mask;
    prio_mode  = mode;
    req_data   = data;
    @(negedge clk_i);
    check("ch_vld_rise", ch_vld, 1);
    check("ch_din", ch_din, exp_din);
    check("busy_send", busy, 1);
    req_data  = ~data;
    prio_mode = ~mode;
    if (drop) req_vld[exp_id] = 1'b0;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk_i);
      check("ch_vld_hold", ch_vld, 1);
      check("ch_din_hold", ch_din, exp_din);
      check("req_ack_early", req_ack, 0);
    end
    ch_ack = 1'b1;
    @(negedge clk_i);
    ch_ack = 1'b0;
    m_cnt  = m_cnt + 16'd1;
    for (int i = 0; i < NREQ; i++) if (req_ack[i]) acks[i]++;
    check("req_ack", req_ack, oh);
    check("ch_vld_fall", ch_vld, 0);
    check("xfer_cnt", xfer_cnt, m_cnt);
    req_vld[exp_id] = 1'b0;
    @(negedge clk_i);
    check("req_ack_pulse", req_ack, 0);
    check("busy_idle", busy, 0);
    req_vld = '0;
    m_ptr   = exp_id;
  endtask

  task automatic do_reset();
    req_vld = '0;
    ch_ack  = 1'b0;
    err_clr = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ptr = NREQ - 1;
    m_cnt = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    mask;
    logic [DW-1:0]      pc [NREQ];
    logic [IDW-1:0]     id;
    bit                 mode;
    int                 low;

    tbl[0] = '{4'b0100, 1'b0, 5, 2'd2};
    tbl[1] = '{4'b1111, 1'b0, 1, 2'd3};
    tbl[2] = '{4'b1111, 1'b0, 2, 2'd0};
    tbl[3] = '{4'b1010, 1'b1, 0, 2'd1};
    tbl[4] = '{4'b1010, 1'b0, 1, 2'd3};
    tbl[5] = '{4'b0110, 1'b0, 2, 2'd1};
    tbl[6] = '{4'b1001, 1'b0, 0, 2'd3};
    tbl[7] = '{4'b1000, 1'b0, 1, 2'd3};
    tbl[8] = '{4'b1100, 1'b1, 2, 2'd2};
    tbl[9] = '{4'b0011, 1'b0, 0, 2'd0};
    for (int i = 0; i < NREQ; i++) acks[i] = 0;

    // Values while reset is held.
    repeat (2) @(negedge clk_i);
    check("rst_ch_vld", ch_vld, 0);
    check("rst_ch_din", ch_din, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_err", err, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Vector table; entry 0 is the single-requester case with payload A5 and a 5-cycle ack.
    for (int v = 0; v < 10; v++) begin
      data = 32'hC3A55A3C ^ (32'h01010101 * v);
      xfer(tbl[v].req, tbl[v].mode, data, tbl[v].delay, tbl[v].exp_id, 1'b0);
    end

    // Round-robin fairness from reset: grants 0,1,2,3,... with per-requester incrementing payloads.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin acks[i] = 0; pc[i] = DW'(i * 64); end
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = pc[i];
      id = IDW'(k % NREQ);
      xfer(4'b1111, 1'b0, data, k % 3, id, 1'b0);
      pc[id] = pc[id] + 1'b1;
    end
    for (int i = 0; i < NREQ; i++) check("rr_ack_count", acks[i], 25);

    // Fixed priority: requester 0 keeps winning; switching back resumes after ptr (0).
    for (int k = 0; k < 10; k++) xfer(4'b1111, 1'b1, $urandom, 0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++)  xfer(4'b1111, 1'b0, $urandom, 1, IDW'((k + 1) % NREQ), 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      mask = NREQ'($urandom_range(1, 15));
      mode = bit'($urandom_range(0, 1));
      data = $urandom;
      xfer(mask, mode, data, $urandom_range(0, 4), model_pick(mask, mode, m_ptr),
           bit'($urandom_range(0, 3) == 0));
    end
    check("err_after_traffic", err, 0);

    // Spurious ack in IDLE sets err without leaving IDLE; clear, then set-wins-over-clear.
    ch_ack = 1'b1;
    @(negedge clk_i);
    ch_ack = 1'b0;
    check("err_set", err, 1);
    check("err_no_state_change", busy, 0);
    check("err_no_vld", ch_vld, 0);
    err_clr = 1'b1;
    @(negedge clk_i);
    err_clr = 1'b0;
    check("err_clr", err, 0);
    ch_ack  = 1'b1;
    err_clr = 1'b1;
    @(negedge clk_i);
    ch_ack  = 1'b0;
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    err_clr = 1'b1;
    @(negedge clk_i);
    err_clr = 1'b0;
    check("err_clr2", err, 0);

    // Reset in SEND aborts at once; requester 0 wins first afterwards.
    req_vld  = 4'b0100;
    req_data = 32'h12345678;
    @(negedge clk_i);
    check("abort_pre_vld", ch_vld, 1);
    #2 rst_i = 1'b0;
    #1;
    check("abort_ch_vld", ch_vld, 0);
    check("abort_req_ack", req_ack, 0);
    check("abort_busy", busy, 0);
    req_vld = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ptr = NREQ - 1;
    m_cnt = '0;
    @(negedge clk_i);
    check("abort_no_ack", req_ack, 0);
    xfer(4'b1111, 1'b0, 32'hDEADBEEF, 1, 2'd0, 1'b0);

    // Counter wrap: preload 0xFFFE, two transfers land on 0xFFFF then 0x0000.
    force dut.xfer_cnt = 16'hFFFE;
    @(negedge clk_i);
    release dut.xfer_cnt;
    m_cnt = 16'hFFFE;
    @(negedge clk_i);
    check("cnt_preload", xfer_cnt, 16'hFFFE);
    xfer(4'b0010, 1'b0, $urandom, 0, 2'd1, 1'b0);
    xfer(4'b0010, 1'b0, $urandom, 0, 2'd1, 1'b0);
    check("cnt_wrap", xfer_cnt, 16'h0000);

    // Gap instance: low time between transfers = DONE + 3 GAP cycles + the IDLE decision cycle.
    g_req_vld = 4'b0011;
    @(negedge clk_i);
    for (int t = 0; t < 4; t++) begin
      check("gap_vld", g_ch_vld, 1);
      check("gap_id", g_ch_din[IDW+DW-1:DW], t % 2);
      g_ch_ack = 1'b1;
      @(negedge clk_i);
      g_ch_ack = 1'b0;
      check("gap_ack", g_req_ack, (t % 2 == 0) ? 4'b0001 : 4'b0010);
      if (t == 3) break;
      g_req_vld[t % 2] = 1'b0;
      low = 1;
      @(negedge clk_i);
      g_req_vld = 4'b0011;
      while (!g_ch_vld && low < 30) begin
        low++;
        @(negedge clk_i);
      end
      check("gap_low_cycles", low, 5);
      check("gap_no_double_ack", g_req_ack, 0);
    end
    g_req_vld = '0;
    check("gap_err", g_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
